// File: rtl/present_round_ctrl_pkg.sv
// Shared constants, FSM state encoding and PRESENT-80 helper functions.
// Latency: n/a (pure combinational helpers, no state).
// Backpressure: n/a.
//
// Contents:
//   BLOCK_W / KEY_W / ROUNDS / CTR_W : cipher geometry (PRESENT-80 only)
//   present_state_t                  : controller FSM state, 2 bits
//   sbox4 / sbox_layer               : 4-bit S-box and its 16-nibble parallel form
//   key_update                       : one step of the 80-bit key schedule
package present_round_ctrl_pkg;

    localparam int BLOCK_W = 64;
    localparam int KEY_W   = 80;
    localparam int ROUNDS  = 31;
    localparam int CTR_W   = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_OUT   = 2'd3
    } present_state_t;

    // PRESENT S-box: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2
    function automatic logic [3:0] sbox4(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0:    y = 4'hC;
            4'h1:    y = 4'h5;
            4'h2:    y = 4'h6;
            4'h3:    y = 4'hB;
            4'h4:    y = 4'h9;
            4'h5:    y = 4'h0;
            4'h6:    y = 4'hA;
            4'h7:    y = 4'hD;
            4'h8:    y = 4'h3;
            4'h9:    y = 4'hE;
            4'hA:    y = 4'hF;
            4'hB:    y = 4'h8;
            4'hC:    y = 4'h4;
            4'hD:    y = 4'h7;
            4'hE:    y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    // S-box applied independently to all 16 nibbles of the state.
    function automatic logic [63:0] sbox_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) begin
            y[4*i +: 4] = sbox4(x[4*i +: 4]);
        end
        return y;
    endfunction

    // Key schedule step. The order matters: rotate first, then substitute
    // the top nibble of the rotated key, then fold the round counter into
    // bits [19:15] of that same rotated key.
    function automatic logic [79:0] key_update(input logic [79:0] k,
                                               input logic [4:0]  rc);
        logic [79:0] r;
        r          = {k[18:0], k[79:19]};   // rotate left by 61
        r[79:76]   = sbox4(r[79:76]);
        r[19:15]   = r[19:15] ^ rc;
        return r;
    endfunction

endpackage

// File: rtl/present_player.sv
// PRESENT P-layer: fixed 64-bit bit permutation, purely combinational.
// Latency: 0 cycles (wiring only).
// Backpressure: n/a.
//
// Ports:
//   din  : 64-bit S-layer output
//   dout : permuted state; bit (16*i) mod 63 takes din[i], bit 63 stays put
module present_player
    import present_round_ctrl_pkg::*;
(
    input  logic [BLOCK_W-1:0] din,
    output logic [BLOCK_W-1:0] dout
);

    // Every output bit is driven exactly once: the map i -> 16*i mod 63 is a
    // bijection on 0..62 because 16 and 63 are coprime.
    for (genvar i = 0; i < BLOCK_W - 1; i++) begin : g_perm
        assign dout[(16 * i) % (BLOCK_W - 1)] = din[i];
    end

    assign dout[BLOCK_W-1] = din[BLOCK_W-1];

endmodule

// File: rtl/present_round_ctrl.sv
// Iterative PRESENT-80 encryptor: one round per clock, 31 rounds plus final key whitening.
// Latency: start accepted on edge 0, valid asserted after edge 32 (33 cycles).
// Backpressure: result held with valid high until out_ready; start ignored while busy.
//
// Ports:
//   clk, rst    : system clock (rising edge), synchronous active-high reset
//   start       : encryption request, only looked at in IDLE
//   plaintext   : 64-bit block, captured on the accepted start edge
//   key         : 80-bit key, captured on the accepted start edge
//   busy        : high in ROUND, FINAL and OUT
//   ciphertext  : result, stable while valid
//   valid       : ciphertext available
//   out_ready   : consumer accepts ciphertext (ignored while valid is low)
//   round_idx   : round counter for debug, 1..31 during ROUND, else 0
module present_round_ctrl
    import present_round_ctrl_pkg::*;
#(
    parameter int BLOCK_W = 64,     // fixed for PRESENT
    parameter int KEY_W   = 80,     // only 80 is supported
    parameter int ROUNDS  = 31
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BLOCK_W-1:0] plaintext,
    input  logic [KEY_W-1:0]   key,
    output logic               busy,
    output logic [BLOCK_W-1:0] ciphertext,
    output logic               valid,
    input  logic               out_ready,
    output logic [4:0]         round_idx
);

    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

    present_state_t     state_q,     state_d;
    logic [BLOCK_W-1:0] state_reg_q, state_reg_d;
    logic [KEY_W-1:0]   key_reg_q,   key_reg_d;
    logic [4:0]         round_ctr_q, round_ctr_d;
    logic [BLOCK_W-1:0] cipher_q,    cipher_d;
    logic               valid_q,     valid_d;

    // Round datapath: addRoundKey -> S-layer -> P-layer. The round key is
    // always the top 64 bits of the current key register.
    logic [BLOCK_W-1:0] round_key;
    logic [BLOCK_W-1:0] keyed_state;
    logic [BLOCK_W-1:0] sbox_out;
    logic [BLOCK_W-1:0] perm_out;

    assign round_key   = key_reg_q[KEY_W-1:KEY_W-BLOCK_W];
    assign keyed_state = state_reg_q ^ round_key;
    assign sbox_out    = sbox_layer(keyed_state);

    present_player u_player (
        .din  (sbox_out),
        .dout (perm_out)
    );

    always_comb begin
        state_d     = state_q;
        state_reg_d = state_reg_q;
        key_reg_d   = key_reg_q;
        round_ctr_d = round_ctr_q;
        cipher_d    = cipher_q;
        valid_d     = valid_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_reg_d = plaintext;
                    key_reg_d   = key;
                    round_ctr_d = 5'd1;
                    state_d     = ST_ROUND;
                end
            end

            ST_ROUND: begin
                state_reg_d = perm_out;
                key_reg_d   = key_update(key_reg_q, round_ctr_q);
                if (round_ctr_q == LAST_ROUND) begin
                    // Counter parks at 0 rather than incrementing, so it
                    // cannot wrap and round_idx reads 0 outside ROUND.
                    round_ctr_d = 5'd0;
                    state_d     = ST_FINAL;
                end else begin
                    round_ctr_d = round_ctr_q + 5'd1;
                end
            end

            ST_FINAL: begin
                // Final whitening with K32; the key register already holds
                // the 32nd round key after the last schedule step.
                state_reg_d = keyed_state;
                cipher_d    = keyed_state;
                valid_d     = 1'b1;
                state_d     = ST_OUT;
            end

            ST_OUT: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            state_reg_q <= '0;
            key_reg_q   <= '0;
            round_ctr_q <= '0;
            cipher_q    <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            state_reg_q <= state_reg_d;
            key_reg_q   <= key_reg_d;
            round_ctr_q <= round_ctr_d;
            cipher_q    <= cipher_d;
            valid_q     <= valid_d;
        end
    end

    // ciphertext comes from its own register so it only changes on the
    // FINAL edge and stays put for the whole OUT phase.
    assign busy       = (state_q != ST_IDLE);
    assign ciphertext = cipher_q;
    assign valid      = valid_q;
    assign round_idx  = round_ctr_q;

endmodule

// File: doc/present_round_ctrl.md
Name: present_round_ctrl

Overview:
Iterative PRESENT-80 encryption controller. It sequences addRoundKey, the S-box layer and the P-layer once per clock over 31 rounds, then applies final key whitening. It owns the state register, the key register, the round counter and the start/valid/ready handshake. It sits between the crypto front-end that supplies plaintext and key, and the consumer of the ciphertext.

Parameters:
- BLOCK_W, default `size (64): cipher state width. Fixed at 64 for PRESENT.
- KEY_W, default 80: key register width. Only 80 is supported.
- ROUNDS, default 31: number of full rounds before final whitening.

Ports:
- Clock  in  1  single system clock, rising edge
- Reset  in  1  synchronous, active-high reset
- start  in  1  request encryption; sampled only in IDLE
- plaintext  in  BLOCK_W  captured on the accepted start edge
- key  in  KEY_W  captured on the accepted start edge
- busy  out  1  high in ROUND, FINAL and OUT
- ciphertext  out  BLOCK_W  result; stable while valid
- valid  out  1  ciphertext available
- out_ready  in  1  consumer accepts ciphertext
- round_idx  out  5  current round counter, for debug

Behaviour:
- Reset (synchronous, Clock edge with Reset=1):
  - state goes to IDLE.
  - state_reg, key_reg, round_ctr and all outputs go to 0: busy=0, valid=0, ciphertext=0, round_idx=0.
  - Reset overrides every other input, including mid-operation. Any in-flight encryption is discarded and no valid pulse follows.
- FSM states: IDLE, ROUND, FINAL, OUT.
- IDLE:
  - On an edge with start=1: state_reg<=plaintext, key_reg<=key, round_ctr<=1, go to ROUND.
  - Otherwise stay in IDLE.
- ROUND, one edge per round:
  - state_reg <= P(S(state_reg ^ key_reg[79:16])).
  - S applies the PRESENT 4-bit S-box to all 16 nibbles.
  - P: output bit (16*i) mod 63 takes input bit i for i in 0..62; bit 63 maps to 63.
  - key_reg update, in order:
    1. Rotate left by 61.
    2. Replace bits [79:76] with S(bits [79:76]).
    3. XOR bits [19:15] with round_ctr.
  - round_ctr increments.
  - When round_ctr==ROUNDS on this edge, go to FINAL instead of continuing.
- FINAL:
  - state_reg <= state_reg ^ key_reg[79:16] (K32).
  - ciphertext is driven from this value; valid<=1; go to OUT.
- OUT:
  - valid stays high and ciphertext is held until an edge with out_ready=1.
  - On that edge: valid<=0 and go to IDLE. The next start is accepted no earlier than the following edge.
- Latency: start sampled at edge 0, rounds on edges 1..31, FINAL on edge 32. valid=1 from after edge 32, so a result is available 33 cycles after acceptance.
- Back-pressure: out_ready may stay low indefinitely; ciphertext must not change while valid.
- start while busy=1 is ignored: not queued, no side effects. plaintext and key are don't-care outside the accept edge.
- out_ready while valid=0 is ignored.
- round_ctr is 5 bits. It never wraps because it stops at 31. round_idx=0 in IDLE and OUT.

Decomposition:
- Constants.sv gains:
  - KEY_W=80, ROUNDS=31.
  - The PRESENT S-box as a function, sbox4: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
  - An FSM state enum, present_state_t, 2 bits.
- One natural sub-module: present_player. It is a purely combinational 64-bit bit permutation, instantiated once in the round datapath.
- The S-box layer and key update are inline functions; they need no extra module.

Test Plan:
- pt=0000000000000000, key=0 -> valid after edge 32, ciphertext=5579C1387B228445; busy high for exactly 33 cycles until acceptance.
- pt=0, key=FFFFFFFFFFFFFFFFFFFF -> E72C46C0F5945049. pt=FFFFFFFFFFFFFFFF, key=0 -> A112FFC72F68417B. Both pt and key all-ones -> 3333DCD3213210D2.
- Back-pressure: hold out_ready=0 for 10 cycles after valid -> ciphertext constant and valid high throughout. Raise out_ready -> valid low next cycle and busy low.
- start pulsed with different pt at edges 5 and 20 of an operation -> ignored; result equals the first vector. A second start the cycle after the handshake completes -> accepted; correct second result.
- Reset=1 at round 15 -> next cycle busy=0, valid=0, round_idx=0, ciphertext=0. A new start then produces the correct vector with full 33-cycle latency.
- round_idx monitor: sequence 1,2,...,31 on consecutive cycles during ROUND; 0 in FINAL/OUT/IDLE.
